// File: rtl/pipeline_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_control_unit_pkg
// Shared encodings for the pipeline control unit: stage one-hot codes (which
// double as the FSM state codes), opcode-group bit indices, control-bus bit
// indices and the bus widths used on the decoder interface.
// -----------------------------------------------------------------------------
package pipeline_control_unit_pkg;

  localparam int STAGE_COUNT  = 5;
  localparam int GROUP_COUNT  = 6;
  localparam int OPCODE_COUNT = 16;
  localparam int SIGNAL_COUNT = 6;

  // Bit positions inside the one-hot stage vector.
  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  // Bit positions inside the opcode-group vector.
  localparam int GROUP_ALU        = 0;
  localparam int GROUP_ALU_TWO_OP = 1;
  localparam int GROUP_LOAD       = 2;
  localparam int GROUP_STORE      = 3;
  localparam int GROUP_REGISTER   = 4;
  localparam int GROUP_BRANCH     = 5;

  // Bit positions inside the control bus.
  localparam int CONTROL_RR_READ   = 0;
  localparam int CONTROL_RD_READ   = 1;
  localparam int CONTROL_RR_WRITE  = 2;
  localparam int CONTROL_RD_WRITE  = 3;
  localparam int CONTROL_MEM_READ  = 4;
  localparam int CONTROL_MEM_WRITE = 5;

  // FSM state codes are the one-hot stage codes, so the state register is
  // driven straight onto the stage output.
  typedef enum logic [STAGE_COUNT-1:0] {
    ST_IF  = 5'b00001,
    ST_ID  = 5'b00010,
    ST_EX  = 5'b00100,
    ST_MEM = 5'b01000,
    ST_WB  = 5'b10000
  } stage_e;

  // True when the instruction touches the data bus.
  function automatic logic is_mem_group(input logic [GROUP_COUNT-1:0] grp);
    return grp[GROUP_LOAD] | grp[GROUP_STORE];
  endfunction

endpackage

// File: rtl/pipeline_control_unit_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// pipeline_control_unit_mem_wait_timer
// Counts MEM wait cycles and flags the cycle whose increment reaches the
// timeout limit. A limit of zero never expires.
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset
//   i_clear    zero the counter (wins over i_enable)
//   i_enable   count one wait cycle
//   o_expired  this cycle's increment reaches MEM_TIMEOUT
// -----------------------------------------------------------------------------
module pipeline_control_unit_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 8,
  parameter int TIMEOUT_W   = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [TIMEOUT_W-1:0] r_count;
  logic [TIMEOUT_W-1:0] w_count_inc;

  assign w_count_inc = r_count + TIMEOUT_W'(1);

  // Looking at the incremented value lets the abort land on the edge that
  // ends the MEM_TIMEOUT-th wait cycle rather than one cycle later.
  assign o_expired = (MEM_TIMEOUT != 0) && i_enable &&
                     (w_count_inc == TIMEOUT_W'(MEM_TIMEOUT));

  // Wait-cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_count_inc;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// -----------------------------------------------------------------------------
// pipeline_control_unit
// Stage FSM (IF, ID, EX, MEM, WB) driving the register-file / bus control bus.
// Handles two-word fetch, mem_ready wait states with timeout abort, optional
// MEM skip for non-memory groups, a global stall and a retire counter.
// Ports:
//   i_clk, i_reset       clock and synchronous active-high reset
//   i_opcode_type        one-hot opcode from the decoder (not needed here)
//   i_opcode_group       one-hot group(s) from the decoder, valid in ID
//   i_two_word           two-word instruction flag, valid in first IF cycle
//   i_mem_ready          bus access completes this cycle (MEM only)
//   i_stall              global hold
//   o_pipeline_stage     one-hot current stage
//   o_fetch_second       second-word IF cycle
//   o_signals            control bus
//   o_instr_done         retire strobe (WB, not stalled)
//   o_mem_timeout        one-cycle flag after a MEM timeout abort
//   o_instr_count        retired-instruction count, wraps silently
// -----------------------------------------------------------------------------
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int SKIP_MEM    = 1,
  parameter int MEM_TIMEOUT = 8,
  parameter int TIMEOUT_W   = 4,
  parameter int INSTR_CNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [OPCODE_COUNT-1:0] i_opcode_type,
  input  logic [GROUP_COUNT-1:0]  i_opcode_group,
  input  logic                    i_two_word,
  input  logic                    i_mem_ready,
  input  logic                    i_stall,
  output logic [STAGE_COUNT-1:0]  o_pipeline_stage,
  output logic                    o_fetch_second,
  output logic [SIGNAL_COUNT-1:0] o_signals,
  output logic                    o_instr_done,
  output logic                    o_mem_timeout,
  output logic [INSTR_CNT_W-1:0]  o_instr_count
);

  stage_e                  r_state;
  stage_e                  w_state_next;
  logic                    r_fetch_second;
  logic                    w_fetch_second_next;
  logic [GROUP_COUNT-1:0]  r_grp;
  logic                    r_mem_timeout;
  logic [INSTR_CNT_W-1:0]  r_instr_count;
  logic [SIGNAL_COUNT-1:0] w_signals;
  logic                    w_in_mem;
  logic                    w_timer_clear;
  logic                    w_timer_enable;
  logic                    w_timer_expired;
  logic                    w_abort;
  logic                    w_retire;
  logic                    w_unused_bits;

  // The opcode itself and two latched group bits carry no control meaning here.
  assign w_unused_bits = ^{i_opcode_type, r_grp[GROUP_ALU_TWO_OP], r_grp[GROUP_BRANCH]};

  assign w_in_mem       = (r_state == ST_MEM);
  assign w_timer_enable = w_in_mem & ~i_stall & ~i_mem_ready;
  // Counter sits at zero outside MEM and is zeroed on the edge leaving MEM.
  assign w_timer_clear  = ~w_in_mem | (~i_stall & (i_mem_ready | w_timer_expired));
  assign w_abort        = w_in_mem & w_timer_expired;
  assign w_retire       = (r_state == ST_WB) & ~i_stall;

  pipeline_control_unit_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TIMEOUT_W   (TIMEOUT_W)
  ) u_mem_wait_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_enable),
    .o_expired (w_timer_expired)
  );

  // Next-state and second-word flag; stall holds everything.
  always_comb begin
    w_state_next        = r_state;
    w_fetch_second_next = r_fetch_second;
    if (i_stall) begin
      w_state_next        = r_state;
      w_fetch_second_next = r_fetch_second;
    end else begin
      case (r_state)
        ST_IF: begin
          if (i_two_word & ~r_fetch_second) begin
            w_state_next        = ST_IF;
            w_fetch_second_next = 1'b1;
          end else begin
            w_state_next        = ST_ID;
            w_fetch_second_next = 1'b0;
          end
        end
        ST_ID: begin
          w_state_next = ST_EX;
        end
        ST_EX: begin
          if (is_mem_group(r_grp) || (SKIP_MEM == 0)) begin
            w_state_next = ST_MEM;
          end else begin
            w_state_next = ST_WB;
          end
        end
        ST_MEM: begin
          // mem_ready beats the timeout when both land on the same cycle.
          if (i_mem_ready) begin
            w_state_next = ST_WB;
          end else if (w_timer_expired) begin
            w_state_next = ST_IF;
          end else begin
            w_state_next = ST_MEM;
          end
        end
        ST_WB: begin
          w_state_next = ST_IF;
        end
        default: begin
          w_state_next        = ST_IF;
          w_fetch_second_next = 1'b0;
        end
      endcase
    end
  end

  // Control bus decode; ID uses the live group, MEM/WB use the latched one.
  always_comb begin
    w_signals = '0;
    if (i_stall) begin
      w_signals = '0;
    end else begin
      case (r_state)
        ST_ID: begin
          w_signals[CONTROL_RR_READ] = i_opcode_group[GROUP_ALU_TWO_OP] | i_opcode_group[GROUP_STORE] |
                                       i_opcode_group[GROUP_LOAD] | i_opcode_group[GROUP_REGISTER];
          w_signals[CONTROL_RD_READ] = i_opcode_group[GROUP_ALU] | i_opcode_group[GROUP_LOAD];
        end
        ST_MEM: begin
          w_signals[CONTROL_MEM_READ]  = r_grp[GROUP_LOAD];
          w_signals[CONTROL_MEM_WRITE] = r_grp[GROUP_STORE];
        end
        ST_WB: begin
          w_signals[CONTROL_RD_WRITE] = r_grp[GROUP_ALU] | r_grp[GROUP_REGISTER] | r_grp[GROUP_LOAD];
        end
        default: begin
          w_signals = '0;
        end
      endcase
    end
  end

  // State, group latch, abort flag and retire counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IF;
      r_fetch_second <= 1'b0;
      r_grp          <= '0;
      r_mem_timeout  <= 1'b0;
      r_instr_count  <= '0;
    end else begin
      r_mem_timeout <= w_abort;
      if (!i_stall) begin
        r_state        <= w_state_next;
        r_fetch_second <= w_fetch_second_next;
        if (r_state == ST_ID) begin
          r_grp <= i_opcode_group;
        end
        if (w_retire) begin
          r_instr_count <= r_instr_count + INSTR_CNT_W'(1);
        end
      end
    end
  end

  assign o_pipeline_stage = r_state;
  assign o_fetch_second   = r_fetch_second;
  assign o_signals        = w_signals;
  assign o_instr_done     = w_retire;
  assign o_mem_timeout    = r_mem_timeout;
  assign o_instr_count    = r_instr_count;

endmodule
